// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, hazard FSM state encoding
// and the all-zero control bundle that pipeline registers load as a bubble.
package pipe_pkg;

  localparam int unsigned REG_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_FAULT    = 2'd2;

  // Control fields carried down the pipeline; a bubble has every bit cleared
  typedef struct packed {
    logic       rwrite;
    logic       mread;
    logic       mwrite;
    logic       branch;
    logic [1:0] alu_op;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use interlock, branch
// flush, memory-wait freeze with timeout, and stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W        = pipe_pkg::REG_W,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned WAIT_W       = 4,
  parameter int unsigned CNT_W        = 16,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_mread,
  input  logic             idex_rwrite,
  input  logic [REG_W-1:0] idex_wreg,
  input  logic             ex_branch_taken,
  input  logic             exmem_mread,
  input  logic             exmem_mwrite,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import pipe_pkg::*;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q;
  logic              mem_req, mem_wait, load_use, frozen, branch_win;

  // Hazard terms from the current cycle's inputs
  always_comb begin
    mem_req  = exmem_mread | exmem_mwrite;
    mem_wait = mem_req & ~mem_ready;
    load_use = idex_mread & idex_rwrite &
               ((id_use_rs1 & (id_rs1 == idex_wreg)) |
                (id_use_rs2 & (id_rs2 == idex_wreg)));
    if (R0_HARDWIRED && (idex_wreg == '0)) begin
      load_use = 1'b0;
    end
    frozen = (state_q == ST_FAULT) | mem_wait;
  end

  // Priority-ordered enable/flush decision; reset presents a hazard-free pipeline
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    branch_win  = 1'b0;
    if (rst) begin
      if (frozen) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        branch_win = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Memory-wait FSM next state; FAULT is only left through reset
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | (state_d == ST_FAULT);
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (~pc_en),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (branch_win),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W    = 3;
  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned WAIT_W   = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_FROZEN = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;

  logic             clk, rst;
  logic [REG_W-1:0] id_rs1, id_rs2, idex_wreg;
  logic             id_use_rs1, id_use_rs2, idex_mread, idex_rwrite;
  logic             ex_branch_taken, exmem_mread, exmem_mwrite, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .CNT_W(CNT_W), .R0_HARDWIRED(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .idex_mread(idex_mread), .idex_rwrite(idex_rwrite), .idex_wreg(idex_wreg),
    .ex_branch_taken(ex_branch_taken), .exmem_mread(exmem_mread), .exmem_mwrite(exmem_mwrite),
    .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: fault flag, run length of consecutive waiting cycles, counter values
  bit m_fault, m_timeout;
  int m_consec, m_stall, m_flush;

  function automatic bit cur_wait();
    return (exmem_mread || exmem_mwrite) && !mem_ready;
  endfunction

  function automatic logic [6:0] expected_ctrl();
    bit lu;
    lu = idex_mread && idex_rwrite && (idex_wreg != 0) &&
         ((id_use_rs1 && id_rs1 == idex_wreg) || (id_use_rs2 && id_rs2 == idex_wreg));
    if (!rst) return C_NORMAL;
    if (m_fault || cur_wait()) return C_FROZEN;
    if (ex_branch_taken) return C_BRANCH;
    if (lu) return C_LDUSE;
    return C_NORMAL;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_timeout = 0; m_consec = 0; m_stall = 0; m_flush = 0;
  endtask

  // Inputs are already applied at the falling edge; check, then advance one cycle
  task automatic step(input string name);
    logic [6:0] exp, got;
    #1;
    exp = expected_ctrl();
    got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ctrl: got %b want %b", name, got, exp);
    end
    checks++;
    if (stall_cnt !== CNT_W'(m_stall)) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, m_stall);
    end
    checks++;
    if (flush_cnt !== CNT_W'(m_flush)) begin
      errors++;
      $display("FAIL %s flush_cnt: got %0d want %0d", name, flush_cnt, m_flush);
    end
    checks++;
    if (mem_timeout !== m_timeout) begin
      errors++;
      $display("FAIL %s mem_timeout: got %b want %b", name, mem_timeout, m_timeout);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (!exp[6] && m_stall < CNT_MAX) m_stall++;
      if (exp == C_BRANCH && m_flush < CNT_MAX) m_flush++;
      if (!m_fault) begin
        if (cur_wait()) begin
          m_consec++;
          if (m_consec > MAX_WAIT) begin
            m_fault = 1;
            m_timeout = 1;
          end
        end else begin
          m_consec = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; idex_wreg = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; idex_mread = 0; idex_rwrite = 0;
    ex_branch_taken = 0; exmem_mread = 0; exmem_mwrite = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    step("reset_edge");
    rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] wreg, input logic use2);
    idex_mread = 1; idex_rwrite = 1; idex_wreg = wreg;
    id_rs2 = 3'd3; id_use_rs2 = use2; id_rs1 = 3'd5; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    set_load_use(3'd3, 1'b1);
    ex_branch_taken = 1; exmem_mread = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step("reset_hold");
    set_idle();
    step("reset_release");
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(3'd3, 1'b1);
    step("load_use");
    idex_mread = 0; idex_rwrite = 0;
    step("load_use_bubble");
    set_idle();
    step("load_use_after");
  endtask

  task automatic test_r0_unused();
    do_reset();
    set_load_use(3'd0, 1'b1);
    id_rs2 = 3'd0;
    step("r0_dest");
    set_load_use(3'd3, 1'b0);
    step("rs2_unused");
    set_idle();
    step("r0_unused_after");
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    set_load_use(3'd3, 1'b1);
    ex_branch_taken = 1;
    step("branch_over_lu");
    set_idle();
    step("branch_after");
  endtask

  task automatic test_mem_wait();
    do_reset();
    exmem_mread = 1; mem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) step("mem_wait");
    mem_ready = 1;
    step("mem_release");
    set_idle();
    exmem_mwrite = 1; mem_ready = 1;
    step("zero_wait_store");
    set_idle();
    step("mem_wait_after");
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_mread = 1; mem_ready = 0;
    for (int i = 0; i < 18; i++) step("timeout_wait");
    mem_ready = 1; ex_branch_taken = 1;
    for (int i = 0; i < 2; i++) step("fault_frozen");
    rst = 1'b0;
    step("fault_reset");
    set_idle();
    step("fault_cleared");
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use(3'd3, 1'b1);
    for (int i = 0; i < 20; i++) step("sat_stall");
    set_idle();
    ex_branch_taken = 1;
    for (int i = 0; i < 18; i++) step("sat_flush");
    set_idle();
    step("sat_after");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 49) != 0);
      id_rs1          = REG_W'($urandom_range(0, 3));
      id_rs2          = REG_W'($urandom_range(0, 3));
      idex_wreg       = REG_W'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      idex_mread      = 1'($urandom_range(0, 1));
      idex_rwrite     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      exmem_mread     = ($urandom_range(0, 3) == 0);
      exmem_mwrite    = ($urandom_range(0, 5) == 0);
      mem_ready       = ($urandom_range(0, 3) != 0);
      step("random");
    end
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    test_reset();
    test_load_use();
    test_r0_unused();
    test_branch_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
